cpu_step_ctrl: RTL and testbench

Execution-step controller for the single-cycle processor. Conditions the KEY step button and run switch in the `CLOCK_50` domain and issues a one-cycle `cpu_en` pulse to the PC and register file: one pulse per debounced press in step mode, or periodic pulses at a switch-selected rate in run mode. An optional PC breakpoint halts run mode. It sits directly upstream of the PC / register-file write enable. It also exposes a step counter for the LCD.

---
 rtl/cpu_step_pkg.sv | 14 +
 rtl/key_debounce.sv | 57 +++++
 rtl/cpu_step_ctrl.sv | 140 ++++++++++++++
 tb/tb_cpu_step_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_step_pkg.sv
// Shared types for the execution-step controller.
// Optional breakpoint/HALT support is enabled by CPU_STEP_BREAKPOINT_EN.
package cpu_step_pkg;

    typedef enum logic [1:0] {
        STEP = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } step_state_t;

    // Idle level of the active-low key path.
    localparam logic SYNC_RST_LVL = 1'b1;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer and counting debouncer for an active-low button.
// Emits a registered one-cycle pulse on each accepted 1->0 transition.
module key_debounce
    import cpu_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic press_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1_q, s2_q;
    logic             lvl_q, lvl_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        lvl_d   = lvl_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (s2_q != lvl_q) begin
            if (cnt_q == CNT_LAST) begin
                lvl_d   = s2_q;
                press_d = lvl_q & ~s2_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q    <= SYNC_RST_LVL;
            s2_q    <= SYNC_RST_LVL;
            lvl_q   <= SYNC_RST_LVL;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= raw_i;
            s2_q    <= s1_q;
            lvl_q   <= lvl_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = lvl_q;
    assign press_o = press_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Step/run controller issuing one-cycle cpu_en pulses to PC and regfile.
// Define CPU_STEP_BREAKPOINT_EN to compile in the PC breakpoint and HALT.
module cpu_step_ctrl
    import cpu_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RATE_BASE       = 50000000,
    parameter int CNT_W           = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_step_n,
    input  logic       sw_run,
    input  logic [2:0] sw_rate,
    input  logic [7:0] pc,
    input  logic [7:0] bp_addr,
    input  logic       bp_arm,
    output logic       cpu_en,
    output logic [7:0] step_count,
    output logic       running,
    output logic       halted
);

    localparam logic [CNT_W-1:0] RATE_BASE_W = CNT_W'(RATE_BASE);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    step_state_t      state_q, state_d;
    logic [CNT_W-1:0] rate_cnt_q, rate_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] rate_period;
    logic             sw_s1_q, sw_s2_q;
    logic             cpu_en_q, cpu_en_d;
    logic [7:0]       step_q, step_d;
    logic             running_q, running_d;
    logic             halted_q, halted_d;
    logic             press, key_lvl;
    logic             tick, bp_hit;
    logic             unused_lvl;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_key (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (key_step_n),
        .level_o(key_lvl),
        .press_o(press)
    );

    assign unused_lvl  = key_lvl;
    assign rate_period = RATE_BASE_W >> sw_rate;
    assign tick        = (rate_cnt_q == period_q - CNT_ONE);

`ifdef CPU_STEP_BREAKPOINT_EN
    assign bp_hit = bp_arm && (pc == bp_addr);
`else
    logic unused_bp;
    assign bp_hit    = 1'b0;
    assign unused_bp = ^{pc, bp_addr, bp_arm};
`endif

    always_comb begin
        state_d    = state_q;
        rate_cnt_d = rate_cnt_q;
        period_d   = period_q;
        cpu_en_d   = 1'b0;
        unique case (state_q)
            STEP: begin
                if (sw_s2_q) begin
                    state_d    = RUN;
                    rate_cnt_d = '0;
                    period_d   = rate_period;
                end else if (press) begin
                    cpu_en_d = 1'b1;
                end
            end
            RUN: begin
                if (!sw_s2_q) begin
                    state_d = STEP;
                end else if (tick) begin
                    rate_cnt_d = '0;
                    period_d   = rate_period;
                    if (bp_hit) state_d  = HALT;
                    else        cpu_en_d = 1'b1;
                end else begin
                    rate_cnt_d = rate_cnt_q + CNT_ONE;
                end
            end
            HALT: begin
                if (!sw_s2_q) begin
                    state_d = STEP;
                end else if (press) begin
                    cpu_en_d   = 1'b1;
                    state_d    = RUN;
                    rate_cnt_d = '0;
                    period_d   = rate_period;
                end
            end
            default: state_d = STEP;
        endcase
        step_d    = cpu_en_d ? step_q + 8'd1 : step_q;
        running_d = (state_d == RUN);
`ifdef CPU_STEP_BREAKPOINT_EN
        halted_d  = (state_d == HALT);
`else
        halted_d  = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= STEP;
            rate_cnt_q <= '0;
            period_q   <= '0;
            sw_s1_q    <= 1'b0;
            sw_s2_q    <= 1'b0;
            cpu_en_q   <= 1'b0;
            step_q     <= 8'd0;
            running_q  <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rate_cnt_q <= rate_cnt_d;
            period_q   <= period_d;
            sw_s1_q    <= sw_run;
            sw_s2_q    <= sw_s1_q;
            cpu_en_q   <= cpu_en_d;
            step_q     <= step_d;
            running_q  <= running_d;
            halted_q   <= halted_d;
        end
    end

    assign cpu_en     = cpu_en_q;
    assign step_count = step_q;
    assign running    = running_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl: vector table plus run/breakpoint/wrap
// sequences, with DEBOUNCE_CYCLES=4 and RATE_BASE=16.
module tb_cpu_step_ctrl;

`ifdef CPU_STEP_BREAKPOINT_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, key_step_n, sw_run, bp_arm;
    logic [2:0] sw_rate;
    logic [7:0] pc, bp_addr;
    logic       cpu_en, running, halted;
    logic [7:0] step_count;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cpu_step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .RATE_BASE      (16),
        .CNT_W          (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_step_n(key_step_n),
        .sw_run    (sw_run),
        .sw_rate   (sw_rate),
        .pc        (pc),
        .bp_addr   (bp_addr),
        .bp_arm    (bp_arm),
        .cpu_en    (cpu_en),
        .step_count(step_count),
        .running   (running),
        .halted    (halted)
    );

    typedef struct {
        logic       rst;
        logic       key;
        logic       swr;
        logic       en;
        logic [7:0] cnt;
        logic       run;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic k, input logic s,
                       input logic e, input logic [7:0] c, input logic rn);
        vec_t v;
        v.rst = r; v.key = k; v.swr = s;
        v.en  = e; v.cnt = c; v.run = rn;
        vt.push_back(v);
    endtask

    task automatic step1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int  n;
        int  exp_cnt;
        int  pulses;
        logic exp_en;

        // reset, clean press, release, bounce
        for (int i = 0; i < 3; i++)  add(0, 1, 0, 0, 8'd0, 0);
        for (int i = 0; i < 6; i++)  add(1, 0, 0, 0, 8'd0, 0);
        add(1, 0, 0, 1, 8'd1, 0);
        for (int i = 0; i < 3; i++)  add(1, 0, 0, 0, 8'd1, 0);
        for (int i = 0; i < 7; i++)  add(1, 1, 0, 0, 8'd1, 0);
        for (int i = 0; i < 12; i++) add(1, ((i / 2) % 2) == 1, 0, 0, 8'd1, 0);
        for (int i = 0; i < 6; i++)  add(1, 1, 0, 0, 8'd1, 0);

        sw_rate = 3'd2;
        pc      = 8'd0;
        bp_addr = 8'h03;
        bp_arm  = 1'b0;
        rst     = 1'b0;
        key_step_n = 1'b1;
        sw_run  = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            rst        = vt[i].rst;
            key_step_n = vt[i].key;
            sw_run     = vt[i].swr;
            step1();
            chk($sformatf("vec%0d.cpu_en", i), 32'(cpu_en), 32'(vt[i].en));
            chk($sformatf("vec%0d.step_count", i), 32'(step_count),
                32'(vt[i].cnt));
            chk($sformatf("vec%0d.running", i), 32'(running), 32'(vt[i].run));
            chk($sformatf("vec%0d.halted", i), 32'(halted), 32'd0);
        end

        // run mode at sw_rate=2: period 4
        exp_cnt = 1;
        sw_run  = 1'b1;
        n = 0;
        do begin step1(); n++; end while (!running && n < 20);
        chk("run_entry_latency", 32'(n), 32'd3);
        for (int k = 1; k <= 8; k++) begin
            step1();
            exp_en = (k % 4 == 0);
            chk($sformatf("run_k%0d.cpu_en", k), 32'(cpu_en), 32'(exp_en));
            if (exp_en) exp_cnt++;
        end
        chk("run.step_count", 32'(step_count), 32'(exp_cnt));
        step1();
        chk("run_k9.cpu_en", 32'(cpu_en), 32'd0);
        sw_run = 1'b0;
        for (int k = 10; k <= 11; k++) begin
            step1();
            chk($sformatf("stop_k%0d.cpu_en", k), 32'(cpu_en), 32'd0);
            chk($sformatf("stop_k%0d.running", k), 32'(running), 32'd1);
        end
        step1();
        chk("stop_due.cpu_en", 32'(cpu_en), 32'd0);
        chk("stop_due.running", 32'(running), 32'd0);
        step1();
        chk("stop.step_count", 32'(step_count), 32'(exp_cnt));

        // breakpoint at pc 3, pc advances with each pulse
        pc     = 8'd0;
        bp_arm = 1'b1;
        sw_run = 1'b1;
        n = 0;
        do begin step1(); n++; end while (!running && n < 20);
        chk("bp_entry_latency", 32'(n), 32'd3);
        for (int k = 1; k <= 16; k++) begin
            step1();
            exp_en = (k % 4 == 0) && !(k == 16 && BP);
            chk($sformatf("bp_k%0d.cpu_en", k), 32'(cpu_en), 32'(exp_en));
            if (exp_en) begin
                pc = pc + 8'd1;
                exp_cnt++;
            end
        end
        chk("bp.halted", 32'(halted), 32'(BP));
        chk("bp.running", 32'(running), 32'(!BP));
        if (BP) begin
            for (int k = 0; k < 6; k++) begin
                step1();
                chk($sformatf("halt_hold%0d.cpu_en", k), 32'(cpu_en), 32'd0);
                chk($sformatf("halt_hold%0d.halted", k), 32'(halted), 32'd1);
            end
            key_step_n = 1'b0;
            n = 0;
            do begin step1(); n++; end while (!cpu_en && n < 20);
            chk("halt_press_latency", 32'(n), 32'd7);
            chk("halt_press.running", 32'(running), 32'd1);
            chk("halt_press.halted", 32'(halted), 32'd0);
            exp_cnt++;
            pc = pc + 8'd1;
        end
        chk("bp.step_count", 32'(step_count), 32'(exp_cnt));
        key_step_n = 1'b1;
        bp_arm     = 1'b0;
        sw_run     = 1'b0;
        n = 0;
        do begin step1(); n++; end while (running && n < 20);
        chk("bp_exit.running", 32'(running), 32'd0);
        chk("bp_exit.halted", 32'(halted), 32'd0);

        // step_count wrap after 256 run-mode pulses
        rst = 1'b0;
        step1();
        step1();
        rst = 1'b1;
        chk("wrap_reset.step_count", 32'(step_count), 32'd0);
        sw_rate = 3'd3;
        sw_run  = 1'b1;
        pulses  = 0;
        n = 0;
        while (pulses < 256 && n < 1500) begin
            step1();
            n++;
            if (cpu_en) begin
                pulses++;
                if (pulses == 255)
                    chk("wrap.step_count_ff", 32'(step_count), 32'hFF);
            end
        end
        chk("wrap.pulses", 32'(pulses), 32'd256);
        chk("wrap.step_count_00", 32'(step_count), 32'h00);
        sw_run = 1'b0;
        step1();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
